// File: rtl/nios_display_key_pio_edge.sv
// Avalon-MM key PIO: synchronise, debounce and edge-capture push-buttons,
// with a maskable level interrupt for the Nios II.
module nios_display_key_pio_edge #(
    parameter int WIDTH           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int EDGE_TYPE       = 1,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE = (IDLE_LEVEL != 0) ? '1 : '0;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_w;
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_dly_q;
    logic [WIDTH-1:0] rise_w, fall_w, edges_w;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_d;
    logic             wr_w;
    logic             unused_w;

    assign sync_w   = sync_q[SYNC_STAGES-1];
    assign wr_w     = chipselect & ~write_n;
    assign unused_w = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= IDLE;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_w[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) stable_d[i] = sync_w[i];
                else                     cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    assign rise_w = stable_q & ~stable_dly_q;
    assign fall_w = ~stable_q & stable_dly_q;

    always_comb begin
        case (EDGE_TYPE)
            0:       edges_w = rise_w;
            1:       edges_w = fall_w;
            default: edges_w = rise_w | fall_w;
        endcase
    end

    // Set has priority over a same-cycle write-1-clear.
    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_w && address == 2'd1) irqmask_d = writedata[WIDTH-1:0];
        if (wr_w && address == 2'd3) edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        edgecap_d = edgecap_d | edges_w;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = stable_q;
            2'd1:    readdata_d[WIDTH-1:0] = irqmask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            stable_q     <= IDLE;
            stable_dly_q <= IDLE;
            irqmask_q    <= '0;
            edgecap_q    <= '0;
            readdata     <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            irqmask_q    <= irqmask_d;
            edgecap_q    <= edgecap_d;
            readdata     <= readdata_d;
        end
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_display_key_pio_edge.sv
// Directed bench: falling-edge PIO alongside an any-edge copy,
// both with a 4-cycle debounce.
module tb_nios_display_key_pio_edge;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [2:0]  in_port;
    logic [31:0] rd, rd_any;
    logic        irq, irq_any;

    int n_chk;
    int n_fail;

    nios_display_key_pio_edge #(
        .WIDTH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE(1), .IDLE_LEVEL(1)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(rd), .irq(irq)
    );

    nios_display_key_pio_edge #(
        .WIDTH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE(2), .IDLE_LEVEL(1)
    ) u_any (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(rd_any), .irq(irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_rd(input logic [1:0] a, input logic [31:0] e,
                          input logic [31:0] e_any, input string tag);
        address = a;
        tick();
        check(tag, rd, e);
        check({tag, "_any"}, rd_any, e_any);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 3'b111;

        // Reset state
        repeat (3) tick();
        check("rst_rd", rd, 32'h0);
        check("rst_irq", irq, 32'h0);
        reset_n = 1'b1;
        bus_rd(2'd0, 32'h7, 32'h7, "rst_data");
        bus_rd(2'd1, 32'h0, 32'h0, "rst_mask");
        bus_rd(2'd3, 32'h0, 32'h0, "rst_edge");
        check("rst_irq2", irq, 32'h0);

        // Bounce on bit1 shorter than the debounce window
        for (int k = 0; k < 10; k++) begin
            in_port = {1'b1, k[0], 1'b1};
            repeat (2) tick();
        end
        repeat (8) tick();
        bus_rd(2'd0, 32'h7, 32'h7, "bnc_data");
        bus_rd(2'd3, 32'h0, 32'h0, "bnc_edge");
        check("bnc_irq", irq, 32'h0);

        // Press key0: stable at edge 6, visible on readdata at edge 7
        address = 2'd0;
        tick();
        in_port = 3'b110;
        repeat (6) tick();
        check("prs_e6", rd, 32'h7);
        tick();
        check("prs_e7", rd, 32'h6);
        check("prs_irq", irq, 32'h0);
        bus_rd(2'd3, 32'h1, 32'h1, "prs_edge");

        // Mask, no-op clear, then real clear
        bus_wr(2'd1, 32'h1);
        check("msk_irq", irq, 32'h1);
        bus_wr(2'd3, 32'h0);
        check("clr0_irq", irq, 32'h1);
        bus_rd(2'd3, 32'h1, 32'h1, "clr0_edge");
        bus_wr(2'd3, 32'h1);
        check("clr1_irq", irq, 32'h0);
        check("clr1_irqa", irq_any, 32'h0);
        bus_rd(2'd3, 32'h0, 32'h0, "clr1_edge");

        // Release key0: only the any-edge copy captures
        in_port = 3'b111;
        repeat (10) tick();
        bus_rd(2'd0, 32'h7, 32'h7, "rel_data");
        bus_rd(2'd3, 32'h0, 32'h1, "rel_edge");
        check("rel_irq", irq, 32'h0);
        check("rel_irqa", irq_any, 32'h1);
        bus_wr(2'd3, 32'h1);
        check("rel_clr", irq_any, 32'h0);

        // Clear lands on the same edge that sets bit0: set wins
        in_port = 3'b110;
        repeat (6) tick();
        address    = 2'd3;
        writedata  = 32'h1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        check("race_irq", irq, 32'h1);
        check("race_irqa", irq_any, 32'h1);
        bus_rd(2'd3, 32'h1, 32'h1, "race_edge");

        // Reset while release is mid-debounce
        in_port = 3'b111;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check("mrst_irq", irq, 32'h0);
        check("mrst_rd", rd, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        bus_rd(2'd0, 32'h7, 32'h7, "mrst_data");
        bus_rd(2'd3, 32'h0, 32'h0, "mrst_edge");

        // Upper write bits ignored, reserved address inert
        bus_wr(2'd1, 32'hFFFF_FFFF);
        bus_rd(2'd1, 32'h7, 32'h7, "wide_mask");
        check("wide_irq", irq, 32'h0);
        bus_wr(2'd2, 32'hFFFF_FFFF);
        bus_rd(2'd2, 32'h0, 32'h0, "resv");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
